mod_inv_param: RTL
==================

Name: mod_inv_param

Overview:
- Parametrised modular inverter for an odd prime modulus MOD < 2^WIDTH.
- Uses a Kaliski-style binary almost-inverse (phase 1), a one-cycle correction, then halving (phase 2).
- Runtime mode selects a plain inverse or a Montgomery inverse.
- Sits beside the field multiplier in the ECC datapath; replaces the fixed 255-bit Montgomery-only inverter.

Parameters:
- WIDTH, 255, operand/result bit width.
- MOD, 2^255-19, odd prime modulus; must satisfy 2^(WIDTH-1) < MOD < 2^WIDTH.
- KW, $clog2(2*WIDTH+1), width of iteration counter k.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  request strobe; accepted when i_valid && o_ready.
- o_ready  out  1  high only in IDLE.
- i_mode  in  1  0 = plain (x^-1 mod MOD); 1 = Montgomery (x^-1 * 2^WIDTH mod MOD).
- i_x  in  WIDTH  operand.
- o_valid  out  1  one-cycle pulse; result/error valid.
- o_result  out  WIDTH  inverse; held stable until next accept.
- o_error  out  1  qualifies o_valid; held with o_result.

Behaviour:
- Reset values:
  - state = IDLE.
  - o_ready = 1 from the first cycle after reset.
  - o_valid = 0, o_result = 0, o_error = 0, k = 0.
- Reset mid-operation aborts immediately; no o_valid is issued for the aborted request.
- Accept: i_x and i_mode are latched on the accept edge; inputs are don't-care afterwards.
- Registers u, v, r, s are WIDTH+1 bits unsigned. On accept: u = MOD, v = x, r = 0, s = 1, k = 0.
- Error: x == 0 or x >= MOD.
  - IDLE -> DONE.
  - o_valid rises 2 cycles after accept with o_error = 1 and o_result = 0.
- States: IDLE -> PH1 -> CORR -> PH2 -> DONE -> IDLE.
- PH1: one iteration per cycle while v != 0, first matching rule applies:
  - u even: u = u/2, s = 2s.
  - v even: v = v/2, r = 2r.
  - u > v: u = (u-v)/2, r = r+s, s = 2s.
  - else: v = (v-u)/2, s = s+r, r = 2r.
  - k increments every iteration.
  - When v == 0 at the start of a cycle, go to CORR. That cycle performs no iteration.
- CORR (1 cycle):
  - r = (r >= MOD) ? r-MOD : r.
  - then r = MOD - r.
  - Now r = x^-1 * 2^k mod MOD, with WIDTH-1 <= k <= 2*WIDTH.
- PH2: target = 0 (plain) or WIDTH (Montgomery).
  - While k > target: r = r even ? r/2 : (r+MOD)/2; k decrements.
  - When k <= target: go to DONE.
  - If k < target in Montgomery mode, PH2 instead doubles: r = 2r, minus MOD if >= MOD; k increments until k == target.
- DONE (1 cycle): o_valid = 1, o_result = r[WIDTH-1:0], o_error = 0; next state IDLE.
- Latency (accept to o_valid): 3 + phase1_iters + |k - target| cycles; worst case <= 4*WIDTH+3.
- i_valid while busy is ignored; there is no queue.

Optional Feature:
- Macro: MOD_INV_CONST_TIME_EN.
- When defined:
  - PH1 always runs exactly 2*WIDTH cycles. Once v == 0, cycles are dummy: registers hold, k holds.
  - PH2 always runs exactly 2*WIDTH cycles, with dummy cycles after target is reached.
  - Latency for every valid input is fixed at 4*WIDTH+3.
  - The error path stays at 2 cycles.
- When undefined: early termination as above; latency is data-dependent.

Decomposition:
- Package mod_inv_pkg contains:
  - state enum (IDLE, PH1, CORR, PH2, DONE).
  - mode enum (MODE_PLAIN = 0, MODE_MONT = 1).
  - constant P25519 = 2^255-19 as the default MOD.
- One combinational sub-module, mod_inv_half: inputs r, MOD; output r even ? r/2 : (r+MOD)/2, computed at WIDTH+1 bits.
- Phase-1 update logic stays inline.

Test Plan:
- Defaults, x = 1, mode 0 -> o_result = 1, o_error = 0.
- Defaults, x = 1, mode 1 -> o_result = 19 (2^255 mod p). Also x = 2, mode 0 -> o_result = (p+1)/2.
- WIDTH = 5, MOD = 23: x = 5 mode 0 -> 14; x = 5 mode 1 -> 11. Sweep all x = 1..22 in both modes against a reference model.
- x = 0 and x = MOD -> o_valid 2 cycles after accept, o_error = 1, o_result = 0. Then a following x = 3 (WIDTH = 5) -> 8.
- Assert i_rst in PH1 -> no o_valid, o_ready = 1 next cycle. A new request then completes correctly; i_valid pulses while busy are ignored.
- With MOD_INV_CONST_TIME_EN, WIDTH = 5 -> every valid x gives latency exactly 23 cycles with correct results.

Source files
------------

// File: rtl/mod_inv_pkg.sv
// Shared types and constants for the parametrised modular inverter.
package mod_inv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    CORR,
    PH2,
    DONE
  } state_e;

  typedef enum logic {
    MODE_PLAIN = 1'b0,
    MODE_MONT  = 1'b1
  } mode_e;

  localparam int unsigned P25519_W = 255;

  // 2^255 - 19: all ones except the low byte 0xED
  localparam logic [P25519_W-1:0] P25519 = {{(P25519_W-8){1'b1}}, 8'hED};

endpackage

// File: rtl/mod_inv_param_if.sv
// Request/response bus of the modular inverter.
interface mod_inv_param_if
  import mod_inv_pkg::*;
#(
  parameter int unsigned WIDTH = 255
);

  logic             i_valid;
  logic             o_ready;
  mode_e            i_mode;
  logic [WIDTH-1:0] i_x;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;
  logic             o_error;

  modport master (
    output i_valid, i_mode, i_x,
    input  o_ready, o_valid, o_result, o_error
  );

  modport slave (
    input  i_valid, i_mode, i_x,
    output o_ready, o_valid, o_result, o_error
  );

endinterface

// File: rtl/mod_inv_half.sv
// Modular halving: r/2 when r is even, (r+MOD)/2 when odd; r < 2^(WIDTH+1) - MOD.
module mod_inv_half
  import mod_inv_pkg::*;
#(
  parameter int unsigned WIDTH = 255
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] mod_i,
  output logic [WIDTH:0]   half_o
);

  logic [WIDTH:0] sum;

  // Adding the odd modulus makes an odd r even without changing its residue
  always_comb begin
    sum    = r_i + {1'b0, mod_i};
    half_o = r_i[0] ? (sum >> 1) : (r_i >> 1);
  end

endmodule

// File: rtl/mod_inv_param.sv
// Kaliski almost-inverse with correction and halving/doubling, plain or Montgomery result.
// Optional build macro MOD_INV_CONST_TIME_EN pads both phases to fixed length.
module mod_inv_param
  import mod_inv_pkg::*;
#(
  parameter int unsigned      WIDTH = 255,
  parameter logic [WIDTH-1:0] MOD   = WIDTH'(P25519),
  parameter int unsigned      KW    = $clog2(2*WIDTH+1)
) (
  input logic            i_clk,
  input logic            i_rst,
  mod_inv_param_if.slave bus
);

  localparam int unsigned   RW     = WIDTH + 1;
  localparam logic [RW-1:0] MOD_X  = {1'b0, MOD};
  localparam logic [KW-1:0] K_MONT = KW'(WIDTH);
`ifdef MOD_INV_CONST_TIME_EN
  localparam logic [KW-1:0] SLOTS  = KW'(2*WIDTH);
`endif

  state_e           state_q;
  logic [RW-1:0]    u_q, v_q, r_q, s_q;
  logic [KW-1:0]    k_q;
  mode_e            mode_q;
  logic             err_q;
  logic             ready_q;
  logic             valid_q;
  logic             error_q;
  logic [WIDTH-1:0] result_q;
`ifdef MOD_INV_CONST_TIME_EN
  logic [KW-1:0]    cnt_q;
`endif

  logic [RW-1:0] u_d, v_d, r_d, s_d;
  logic [RW-1:0] r_red, r_corr, r_half, r_dbl, r_dbl_red;
  logic [KW-1:0] target;
  logic          accept;
  logic          x_err;

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_error  = error_q;

  // One phase-1 iteration; first matching rule wins
  always_comb begin
    u_d = u_q;
    v_d = v_q;
    r_d = r_q;
    s_d = s_q;
    if (!u_q[0]) begin
      u_d = u_q >> 1;
      s_d = s_q << 1;
    end else if (!v_q[0]) begin
      v_d = v_q >> 1;
      r_d = r_q << 1;
    end else if (u_q > v_q) begin
      u_d = (u_q - v_q) >> 1;
      r_d = r_q + s_q;
      s_d = s_q << 1;
    end else begin
      v_d = (v_q - u_q) >> 1;
      s_d = s_q + r_q;
      r_d = r_q << 1;
    end
  end

  // Correction, doubling and request qualification
  always_comb begin
    r_red     = (r_q >= MOD_X) ? (r_q - MOD_X) : r_q;
    r_corr    = MOD_X - r_red;
    r_dbl     = r_q << 1;
    r_dbl_red = (r_dbl >= MOD_X) ? (r_dbl - MOD_X) : r_dbl;
    target    = (mode_q == MODE_MONT) ? K_MONT : '0;
    accept    = bus.i_valid && ready_q;
    x_err     = (bus.i_x == '0) || (bus.i_x >= MOD);
  end

  mod_inv_half #(
    .WIDTH (WIDTH)
  ) u_half (
    .r_i    (r_q),
    .mod_i  (MOD),
    .half_o (r_half)
  );

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      u_q      <= '0;
      v_q      <= '0;
      r_q      <= '0;
      s_q      <= '0;
      k_q      <= '0;
      mode_q   <= MODE_PLAIN;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
`ifdef MOD_INV_CONST_TIME_EN
      cnt_q    <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            u_q     <= MOD_X;
            v_q     <= {1'b0, bus.i_x};
            r_q     <= '0;
            s_q     <= RW'(1);
            k_q     <= '0;
            mode_q  <= bus.i_mode;
            err_q   <= x_err;
            ready_q <= 1'b0;
            state_q <= PH1;
`ifdef MOD_INV_CONST_TIME_EN
            cnt_q   <= '0;
`endif
          end
        end
        PH1: begin
`ifdef MOD_INV_CONST_TIME_EN
          if (err_q || (cnt_q == SLOTS)) begin
            state_q <= CORR;
          end else begin
            cnt_q <= cnt_q + KW'(1);
            if (v_q != '0) begin
              u_q <= u_d;
              v_q <= v_d;
              r_q <= r_d;
              s_q <= s_d;
              k_q <= k_q + KW'(1);
            end
          end
`else
          if (err_q || (v_q == '0)) begin
            state_q <= CORR;
          end else begin
            u_q <= u_d;
            v_q <= v_d;
            r_q <= r_d;
            s_q <= s_d;
            k_q <= k_q + KW'(1);
          end
`endif
        end
        CORR: begin
          if (err_q) begin
            valid_q  <= 1'b1;
            error_q  <= 1'b1;
            result_q <= '0;
            state_q  <= DONE;
          end else begin
            r_q     <= r_corr;
            state_q <= PH2;
`ifdef MOD_INV_CONST_TIME_EN
            cnt_q   <= '0;
`endif
          end
        end
        PH2: begin
`ifdef MOD_INV_CONST_TIME_EN
          if (cnt_q == SLOTS) begin
            valid_q  <= 1'b1;
            error_q  <= 1'b0;
            result_q <= r_q[WIDTH-1:0];
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + KW'(1);
            if (k_q > target) begin
              r_q <= r_half;
              k_q <= k_q - KW'(1);
            end else if (k_q < target) begin
              r_q <= r_dbl_red;
              k_q <= k_q + KW'(1);
            end
          end
`else
          if (k_q > target) begin
            r_q <= r_half;
            k_q <= k_q - KW'(1);
          end else if (k_q < target) begin
            r_q <= r_dbl_red;
            k_q <= k_q + KW'(1);
          end else begin
            valid_q  <= 1'b1;
            error_q  <= 1'b0;
            result_q <= r_q[WIDTH-1:0];
            state_q  <= DONE;
          end
`endif
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
